// File: rtl/seq_divider_32bit.sv
// Multi-cycle restoring divider for DIV/DIVU: one trial subtraction per clock, quotient to LO, remainder to HI.
// Optional macro DIV_SIGNED_EN adds signed division (magnitude divide plus a FIX sign-correction state).
`timescale 1ns/1ps

module subtractor_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] difference,
   output logic        borrow_out
);
   logic [32:0] sum;

   // borrow_out is the carry of a + ~b + 1, so 1 means a >= b (no borrow)
   assign sum        = {1'b0, a} + {1'b0, ~b} + 33'd1;
   assign difference = sum[31:0];
   assign borrow_out = sum[32];
endmodule

module seq_divider_32bit #(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] ZERO_Q = 32'hFFFFFFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state;
   logic [5:0]       cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] trial;
   logic [WIDTH-1:0] sub_a;
   logic [WIDTH-1:0] sub_b;
   logic [WIDTH-1:0] sub_diff;
   logic             sub_nb;
   logic             accept;
   logic [WIDTH-1:0] dvd_abs;
   logic [WIDTH-1:0] dsr_abs;

   assign trial  = {remainder[WIDTH-2:0], dvd[WIDTH-1]};
   // rem[31] set means the shifted trial really has a 33rd bit and always exceeds the divisor
   assign accept = remainder[WIDTH-1] | sub_nb;

   subtractor_32bit u_sub (
      .a          (sub_a),
      .b          (sub_b),
      .difference (sub_diff),
      .borrow_out (sub_nb)
   );

`ifdef DIV_SIGNED_EN
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH-1:0] neg_b;
   logic [WIDTH-1:0] neg_diff;
   logic             neg_borrow_unused;

   // Outside RUN the main subtractor is free and doubles as a second negator
   always_comb begin
      sub_a = trial;
      sub_b = dsr;
      if (state == IDLE) begin
         sub_a = '0;
         sub_b = divisor;
      end else if (state == FIX) begin
         sub_a = '0;
         sub_b = remainder;
      end
   end

   assign neg_b = (state == FIX) ? quotient : dividend;

   subtractor_32bit u_neg (
      .a          ('0),
      .b          (neg_b),
      .difference (neg_diff),
      .borrow_out (neg_borrow_unused)
   );

   assign dvd_abs = (signed_op & dividend[WIDTH-1]) ? neg_diff : dividend;
   assign dsr_abs = (signed_op & divisor[WIDTH-1])  ? sub_diff : divisor;
`else
   logic unused_signed_op;

   assign unused_signed_op = signed_op;
   assign sub_a   = trial;
   assign sub_b   = dsr;
   assign dvd_abs = dividend;
   assign dsr_abs = divisor;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         dvd       <= '0;
         dsr       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
`ifdef DIV_SIGNED_EN
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy     <= 1'b1;
                  cnt      <= '0;
                  div_zero <= (divisor == '0);
`ifdef DIV_SIGNED_EN
                  neg_q    <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  neg_r    <= signed_op & dividend[WIDTH-1];
`endif
                  if (divisor == '0) begin
                     quotient  <= ZERO_Q;
                     remainder <= dividend;
                     done      <= 1'b1;
                     state     <= DONE;
                  end else begin
                     quotient  <= '0;
                     remainder <= '0;
                     dvd       <= dvd_abs;
                     dsr       <= dsr_abs;
                     state     <= RUN;
                  end
               end
            end
            RUN: begin
               remainder <= accept ? sub_diff : trial;
               quotient  <= {quotient[WIDTH-2:0], accept};
               dvd       <= dvd << 1;
               cnt       <= cnt + 6'd1;
               if (cnt == 6'd31) begin
`ifdef DIV_SIGNED_EN
                  state <= FIX;
`else
                  state <= DONE;
                  done  <= 1'b1;
`endif
               end
            end
            FIX: begin
`ifdef DIV_SIGNED_EN
               if (neg_q) quotient <= neg_diff;
               if (neg_r) remainder <= sub_diff;
               done  <= 1'b1;
               state <= DONE;
`else
               state <= IDLE;
`endif
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider_32bit.sv
// Self-checking bench for seq_divider_32bit: arithmetic reference model, per-cycle compare, directed vectors.
`timescale 1ns/1ps

module tb_seq_divider_32bit;
`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif
   localparam int LAT = SIGNED_EN ? 34 : 33;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        signed_op = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] quotient;
   logic [31:0] remainder;

   seq_divider_32bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .signed_op (signed_op),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Reference state: current operation, accept cycle and latency
   bit          active = 1'b0;
   int          acc = 0;
   int          lat = 0;
   logic [31:0] exp_q = '0;
   logic [31:0] exp_r = '0;
   logic        exp_z = 1'b0;
   int          done_cyc = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic z, output int l);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      z  = 1'b0;
      l  = LAT;
      if (b == 32'd0) begin
         q = 32'hFFFFFFFF;
         r = a;
         z = 1'b1;
         l = 1;
      end else if (SIGNED_EN && s) begin
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   always @(negedge clk) begin
      logic eb;
      logic ed;
      if (!rst_n) begin
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_div_zero", 32'(div_zero), 32'd0);
         chk("rst_quotient", quotient, 32'd0);
         chk("rst_remainder", remainder, 32'd0);
      end else begin
         eb = active && (cyc > acc) && (cyc <= acc + lat);
         ed = active && (cyc == acc + lat);
         chk("busy", 32'(busy), 32'(eb));
         chk("done", 32'(done), 32'(ed));
         if (done) done_cyc = cyc;
         if (!active || cyc >= acc + lat) begin
            chk("quotient", quotient, exp_q);
            chk("remainder", remainder, exp_r);
            chk("div_zero", 32'(div_zero), 32'(exp_z));
         end
      end
   end

   function automatic bit model_idle();
      return !active || (cyc > acc + lat);
   endfunction

   // Called just after a rising edge; start stays high for exactly one cycle
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      if (model_idle()) begin
         model(a, b, s, exp_q, exp_r, exp_z, lat);
         acc      = cyc;
         active   = 1'b1;
         done_cyc = -1;
      end
      start     = 1'b1;
      dividend  = a;
      divisor   = b;
      signed_op = s;
      @(posedge clk);
      #1;
      start     = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      signed_op = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && !model_idle(); i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic lit(input string name, input logic [31:0] q, input logic [31:0] r,
                      input logic z, input int l);
      wait_idle();
      chk({name, "_q"}, quotient, q);
      chk({name, "_r"}, remainder, r);
      chk({name, "_dz"}, 32'(div_zero), 32'(z));
      chk({name, "_latency"}, 32'(done_cyc - acc), 32'(l));
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
   } vec_t;

   vec_t vecs[$];

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(32'd100, 32'd7, 1'b0);
      lit("t1_100_div_7", 32'd14, 32'd2, 1'b0, LAT);

      issue(32'hFFFFFFFF, 32'h80000001, 1'b0);
      lit("t2_big_divisor", 32'd1, 32'h7FFFFFFE, 1'b0, LAT);

      issue(32'h1234, 32'd0, 1'b0);
      lit("t3_div_by_zero", 32'hFFFFFFFF, 32'h1234, 1'b1, 1);

      issue(32'd100, 32'd7, 1'b0);
      while (cyc < acc + 10) begin
         @(posedge clk);
         #1;
      end
      issue(32'd5, 32'd1, 1'b0);
      lit("t4_start_while_busy", 32'd14, 32'd2, 1'b0, LAT);

      issue(32'd1000, 32'd3, 1'b0);
      while (cyc < acc + 20) begin
         @(posedge clk);
         #1;
      end
      rst_n  = 1'b0;
      active = 1'b0;
      exp_q  = '0;
      exp_r  = '0;
      exp_z  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("t4_reset_no_done", 32'(done_cyc), 32'hFFFFFFFF);
      chk("t4_reset_quotient", quotient, 32'd0);

      issue(32'hFFFFFFF9, 32'd2, 1'b1);
      if (SIGNED_EN) lit("t5_signed_neg7_div_2", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
      else           lit("t5_unsigned_fff9_div_2", 32'h7FFFFFFC, 32'd1, 1'b0, 33);

      issue(32'h80000000, 32'hFFFFFFFF, 1'b1);
      if (SIGNED_EN) lit("t6_signed_overflow", 32'h80000000, 32'd0, 1'b0, 34);
      else           lit("t6_unsigned_8000_div_ffff", 32'd0, 32'h80000000, 1'b0, 33);

      issue(32'd50, 32'd5, 1'b0);
      while (cyc < acc + lat) begin
         @(posedge clk);
         #1;
      end
      issue(32'd9, 32'd2, 1'b0);
      issue(32'd9, 32'd2, 1'b0);
      lit("t7_start_after_done", 32'd4, 32'd1, 1'b0, LAT);

      vecs.push_back('{32'd0, 32'd5, 1'b0});
      vecs.push_back('{32'd5, 32'd5, 1'b0});
      vecs.push_back('{32'd7, 32'd100, 1'b0});
      vecs.push_back('{32'hFFFFFFFF, 32'd1, 1'b0});
      vecs.push_back('{32'h12345678, 32'hFFFFFFFF, 1'b0});
      vecs.push_back('{32'hDEADBEEF, 32'h1234, 1'b0});
      vecs.push_back('{32'hDEADBEEF, 32'h1234, 1'b1});
      vecs.push_back('{32'd100, 32'hFFFFFFF9, 1'b1});
      vecs.push_back('{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1});
      vecs.push_back('{32'h80000000, 32'd0, 1'b1});
      foreach (vecs[i]) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].s);
         wait_idle();
      end

      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
